// File: rtl/score_bcd_display_pkg.sv
// Segment codes (active-low, bit order {g..a}), FSM state type and constant helpers
// shared by the score display datapath and its digit decoders.
package score_display_pkg;

  localparam logic [6:0] SEG_0     = 7'b100_0000;
  localparam logic [6:0] SEG_1     = 7'b111_1001;
  localparam logic [6:0] SEG_2     = 7'b010_0100;
  localparam logic [6:0] SEG_3     = 7'b011_0000;
  localparam logic [6:0] SEG_4     = 7'b001_1001;
  localparam logic [6:0] SEG_5     = 7'b001_0010;
  localparam logic [6:0] SEG_6     = 7'b000_0010;
  localparam logic [6:0] SEG_7     = 7'b111_1000;
  localparam logic [6:0] SEG_8     = 7'b000_0000;
  localparam logic [6:0] SEG_9     = 7'b001_1000;
  localparam logic [6:0] SEG_BLANK = 7'b111_1111;
  localparam logic [6:0] SEG_DASH  = 7'b011_1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  function automatic logic [6:0] seg_lookup(input logic [3:0] nib);
    case (nib)
      4'd0:    seg_lookup = SEG_0;
      4'd1:    seg_lookup = SEG_1;
      4'd2:    seg_lookup = SEG_2;
      4'd3:    seg_lookup = SEG_3;
      4'd4:    seg_lookup = SEG_4;
      4'd5:    seg_lookup = SEG_5;
      4'd6:    seg_lookup = SEG_6;
      4'd7:    seg_lookup = SEG_7;
      4'd8:    seg_lookup = SEG_8;
      4'd9:    seg_lookup = SEG_9;
      default: seg_lookup = SEG_DASH;
    endcase
  endfunction

  function automatic logic [63:0] pow10(input int n);
    pow10 = 64'd1;
    for (int i = 0; i < n; i++) begin
      pow10 = pow10 * 64'd10;
    end
  endfunction

endpackage

// File: rtl/score_bcd_display_if.sv
// Score-to-display bus: load/busy request handshake plus the latched BCD/segment result.
// The score source drives the master side; the converter is the slave.
interface score_bcd_display_if #(
  parameter int BIN_W  = 9,
  parameter int DIGITS = 3
);
  logic [BIN_W-1:0]    score;
  logic                load;
  logic                busy;
  logic                done;
  logic                overflow;
  logic [4*DIGITS-1:0] bcd;
  logic [7*DIGITS-1:0] hex;

  modport master (
    output score, load,
    input  busy, done, overflow, bcd, hex
  );

  modport slave (
    input  score, load,
    output busy, done, overflow, bcd, hex
  );
endinterface

// File: rtl/score_bcd_display_seg7_digit.sv
// Combinational nibble -> seven-segment decoder with blank override; zero latency.
// Non-BCD nibbles show a dash; ACTIVE_LOW=0 inverts every code including blank.
module seg7_digit
  import score_display_pkg::*;
#(
  parameter int ACTIVE_LOW = 1
) (
  input  logic [3:0] i_nib,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  logic [6:0] w_code;

  always_comb begin
    w_code = i_blank ? SEG_BLANK : seg_lookup(i_nib);
  end

  assign o_seg = (ACTIVE_LOW != 0) ? w_code : ~w_code;

endmodule

// File: rtl/score_bcd_display.sv
// Sequential double-dabble score -> DIGITS BCD digits -> seven-segment, with blanking/saturation.
// Done pulses BIN_W+2 clocks after load is taken; load while busy is dropped (no queueing).
module score_bcd_display
  import score_display_pkg::*;
#(
  parameter int BIN_W      = 9,
  parameter int DIGITS     = 3,
  parameter int BLANK_LZ   = 1,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  score_bcd_display_if.slave   bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int ACC_W = BCD_W + 4;
  localparam int NIBS  = ACC_W / 4;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [63:0] MAX_VAL = pow10(DIGITS) - 64'd1;

  function automatic logic [7*DIGITS-1:0] hex_reset();
    logic [6:0] code;
    hex_reset = '0;
    for (int i = 0; i < DIGITS; i++) begin
      code = (i == 0 || BLANK_LZ == 0) ? SEG_0 : SEG_BLANK;
      if (ACTIVE_LOW == 0) code = ~code;
      hex_reset[7*i +: 7] = code;
    end
  endfunction

  localparam logic [7*DIGITS-1:0] HEX_RST = hex_reset();

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_start;
  logic                w_shift;
  logic                w_latch;

  logic [BIN_W-1:0]    r_bin;
  logic [ACC_W-1:0]    r_acc;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_ovf_q;

  logic [ACC_W-1:0]    w_adj;
  logic [BCD_W-1:0]    w_bcd_sat;
  logic [DIGITS-1:0]   w_blank;
  logic                w_hi_zero;
  logic [7*DIGITS-1:0] w_hex;

  logic [BCD_W-1:0]    r_bcd;
  logic [7*DIGITS-1:0] r_hex;
  logic                r_ovf;
  logic                r_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // SHIFT spends one extra cycle at count zero so results land BIN_W+2 edges after load.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_shift     = 1'b0;
    w_latch     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.load) begin
          w_start     = 1'b1;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (r_cnt == '0) w_state_nxt = ST_LATCH;
        else             w_shift     = 1'b1;
      end
      ST_LATCH: begin
        w_latch     = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_adj = r_acc;
    for (int i = 0; i < NIBS; i++) begin
      if (r_acc[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bin   <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf_q <= 1'b0;
    end else if (w_start) begin
      r_bin   <= bus.score;
      r_acc   <= '0;
      r_cnt   <= CNT_W'(BIN_W);
      r_ovf_q <= (64'(bus.score) > MAX_VAL);
    end else if (w_shift) begin
      r_acc   <= ACC_W'({w_adj, r_bin[BIN_W-1]});
      r_bin   <= {r_bin[BIN_W-2:0], 1'b0};
      r_cnt   <= r_cnt - 1'b1;
    end
  end

  assign w_bcd_sat = r_ovf_q ? {DIGITS{4'h9}} : r_acc[BCD_W-1:0];

  // Walk from the top digit down: a digit blanks only while everything above it is zero.
  always_comb begin
    w_blank   = '0;
    w_hi_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      w_hi_zero  = w_hi_zero && (w_bcd_sat[4*i +: 4] == 4'h0);
      w_blank[i] = (BLANK_LZ != 0) && !r_ovf_q && w_hi_zero;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    seg7_digit #(
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_seg (
      .i_nib   (w_bcd_sat[4*g +: 4]),
      .i_blank (w_blank[g]),
      .o_seg   (w_hex[7*g +: 7])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bcd  <= '0;
      r_hex  <= HEX_RST;
      r_ovf  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_latch;
      if (w_latch) begin
        r_bcd <= w_bcd_sat;
        r_hex <= w_hex;
        r_ovf <= r_ovf_q;
      end
    end
  end

  assign bus.busy     = (r_state != ST_IDLE);
  assign bus.done     = r_done;
  assign bus.overflow = r_ovf;
  assign bus.bcd      = r_bcd;
  assign bus.hex      = r_hex;

endmodule

// File: tb/tb_score_bcd_display.sv
// Directed bench for score_bcd_display: a 3-digit and a 2-digit instance on one clock/reset.
module tb_score_bcd_display;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  score_bcd_display_if #(.BIN_W(9), .DIGITS(3)) if3 ();
  score_bcd_display_if #(.BIN_W(9), .DIGITS(2)) if2 ();

  score_bcd_display #(.BIN_W(9), .DIGITS(3), .BLANK_LZ(1), .ACTIVE_LOW(1)) u_dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (if3.slave)
  );

  score_bcd_display #(.BIN_W(9), .DIGITS(2), .BLANK_LZ(1), .ACTIVE_LOW(1)) u_dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (if2.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Leaves the bench 1 time unit after the edge that samples load (E0).
  task automatic start(input bit use2, input logic [8:0] s);
    @(posedge clk); #1;
    if (use2) begin if2.score = s; if2.load = 1'b1; end
    else      begin if3.score = s; if3.load = 1'b1; end
    @(posedge clk); #1;
    if2.load = 1'b0;
    if3.load = 1'b0;
  endtask

  task automatic wait_done(input bit use2, output int n);
    n = 0;
    while (!(use2 ? if2.done : if3.done) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_seen", 32'(use2 ? if2.done : if3.done), 32'd1);
  endtask

  initial begin
    int n;
    int seen;
    if3.score = '0; if3.load = 1'b0;
    if2.score = '0; if2.load = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(if3.busy), 32'd0);
    chk("rst_done", 32'(if3.done), 32'd0);
    chk("rst_ovf",  32'(if3.overflow), 32'd0);
    chk("rst_bcd",  32'(if3.bcd), 32'h000);
    chk("rst_hex",  32'(if3.hex), 32'({7'h7F, 7'h7F, 7'h40}));
    chk("rst_hex2", 32'(if2.hex), 32'({7'h7F, 7'h40}));
    reset = 1'b0;

    start(1'b0, 9'd0);
    chk("busy_after_load", 32'(if3.busy), 32'd1);
    wait_done(1'b0, n);
    chk("lat_zero", 32'(n), 32'd11);
    chk("busy_in_done", 32'(if3.busy), 32'd0);
    chk("bcd_zero", 32'(if3.bcd), 32'h000);
    chk("hex_zero", 32'(if3.hex), 32'({7'h7F, 7'h7F, 7'h40}));
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(if3.done), 32'd0);

    start(1'b0, 9'd511);
    wait_done(1'b0, n);
    chk("bcd_511", 32'(if3.bcd), 32'h511);
    chk("hex_511", 32'(if3.hex), 32'({7'h12, 7'h79, 7'h79}));
    chk("ovf_511", 32'(if3.overflow), 32'd0);

    start(1'b0, 9'd7);
    wait_done(1'b0, n);
    chk("bcd_7", 32'(if3.bcd), 32'h007);
    chk("hex_7", 32'(if3.hex), 32'({7'h7F, 7'h7F, 7'h78}));
    @(posedge clk); #1;
    chk("hold_bcd_7", 32'(if3.bcd), 32'h007);

    start(1'b0, 9'd250);
    repeat (2) begin
      @(posedge clk); #1;
      if3.score = 9'd123; if3.load = 1'b1;
      @(posedge clk); #1;
      if3.load = 1'b0;
    end
    wait_done(1'b0, n);
    chk("bcd_busy_ignored", 32'(if3.bcd), 32'h250);
    chk("hex_250", 32'(if3.hex), 32'({7'h24, 7'h12, 7'h40}));
    if3.score = 9'd42; if3.load = 1'b1;
    @(posedge clk); #1;
    if3.load = 1'b0;
    chk("b2b_busy", 32'(if3.busy), 32'd1);
    wait_done(1'b0, n);
    chk("lat_b2b", 32'(n), 32'd11);
    chk("bcd_42", 32'(if3.bcd), 32'h042);
    chk("hex_42", 32'(if3.hex), 32'({7'h7F, 7'h19, 7'h24}));

    start(1'b1, 9'd150);
    wait_done(1'b1, n);
    chk("d2_bcd_150", 32'(if2.bcd), 32'h99);
    chk("d2_ovf_150", 32'(if2.overflow), 32'd1);
    chk("d2_hex_150", 32'(if2.hex), 32'({7'h18, 7'h18}));

    start(1'b1, 9'd99);
    wait_done(1'b1, n);
    chk("d2_bcd_99", 32'(if2.bcd), 32'h99);
    chk("d2_ovf_99", 32'(if2.overflow), 32'd0);

    start(1'b1, 9'd100);
    wait_done(1'b1, n);
    chk("d2_ovf_100", 32'(if2.overflow), 32'd1);
    chk("d2_bcd_100", 32'(if2.bcd), 32'h99);

    start(1'b1, 9'd5);
    wait_done(1'b1, n);
    chk("d2_bcd_5", 32'(if2.bcd), 32'h05);
    chk("d2_ovf_5", 32'(if2.overflow), 32'd0);
    chk("d2_hex_5", 32'(if2.hex), 32'({7'h7F, 7'h12}));

    start(1'b0, 9'd123);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("midrst_busy", 32'(if3.busy), 32'd0);
    chk("midrst_done", 32'(if3.done), 32'd0);
    chk("midrst_bcd",  32'(if3.bcd), 32'h000);
    chk("midrst_hex",  32'(if3.hex), 32'({7'h7F, 7'h7F, 7'h40}));
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    seen = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (if3.done) seen++;
    end
    chk("midrst_no_done", 32'(seen), 32'd0);

    start(1'b0, 9'd305);
    wait_done(1'b0, n);
    chk("lat_305", 32'(n), 32'd11);
    chk("bcd_305", 32'(if3.bcd), 32'h305);
    chk("hex_305", 32'(if3.hex), 32'({7'h30, 7'h40, 7'h12}));
    chk("ovf_305", 32'(if3.overflow), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
